// File: rtl/mem_copy_dma_pkg.sv
// Shared types and constants for the word-RAM copy/fill DMA initiator.
// Address helpers keep pointer arithmetic identical everywhere it is used.
package mem_copy_dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } dma_state_e;

  localparam logic [3:0] BeFull    = 4'hF;
  localparam int         WordBytes = 4;

  // Force a byte address onto its word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Advance one word; 32-bit modulo so 0xFFFF_FFFC wraps to 0x0.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'(WordBytes);
  endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Copy/fill DMA initiator on the single-port word RAM bus (req/gnt/rvalid).
// One transaction outstanding at a time; all bus outputs are registered.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int LenW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [31:0]     src_i,
  input  logic [31:0]     dst_i,
  input  logic [LenW-1:0] len_i,
  input  logic [31:0]     pattern_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            req_o,
  input  logic            gnt_i,
  output logic            we_o,
  output logic [3:0]      be_o,
  output logic [31:0]     addr_o,
  output logic [31:0]     wdata_o,
  input  logic            rvalid_i,
  input  logic [31:0]     rdata_i
);

  dma_state_e      state_r,     state_s;
  logic [31:0]     src_ptr_r,   src_ptr_s;
  logic [31:0]     dst_ptr_r,   dst_ptr_s;
  logic [LenW-1:0] remaining_r, remaining_s;
  logic            mode_r,      mode_s;
  logic [31:0]     data_r,      data_s;

  logic            busy_r,  busy_s;
  logic            done_r,  done_s;
  logic            req_r,   req_s;
  logic            we_r,    we_s;
  logic [3:0]      be_r,    be_s;
  logic [31:0]     addr_r,  addr_s;
  logic [31:0]     wdata_r, wdata_s;

  // Next-state and datapath register update.
  always_comb begin
    state_s     = state_r;
    src_ptr_s   = src_ptr_r;
    dst_ptr_s   = dst_ptr_r;
    remaining_s = remaining_r;
    mode_s      = mode_r;
    data_s      = data_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          src_ptr_s   = align_word(src_i);
          dst_ptr_s   = align_word(dst_i);
          remaining_s = len_i;
          mode_s      = mode_i;
          data_s      = pattern_i;
          if (len_i == {LenW{1'b0}}) begin
            state_s = DONE;
          end else if (mode_i) begin
            state_s = WR_REQ;
          end else begin
            state_s = RD_REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_REQ: begin
        if (gnt_i) begin
          state_s = RD_WAIT;
        end else begin
          state_s = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (rvalid_i) begin
          data_s  = rdata_i;
          state_s = WR_REQ;
        end else begin
          state_s = RD_WAIT;
        end
      end
      WR_REQ: begin
        if (gnt_i) begin
          state_s = WR_WAIT;
        end else begin
          state_s = WR_REQ;
        end
      end
      WR_WAIT: begin
        if (rvalid_i) begin
          remaining_s = remaining_r - LenW'(1);
          dst_ptr_s   = next_word(dst_ptr_r);
          if (!mode_r) begin
            src_ptr_s = next_word(src_ptr_r);
          end else begin
            src_ptr_s = src_ptr_r;
          end
          if (remaining_r == LenW'(1)) begin
            state_s = DONE;
          end else if (mode_r) begin
            state_s = WR_REQ;
          end else begin
            state_s = RD_REQ;
          end
        end else begin
          state_s = WR_WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bus outputs decoded from the next state so they can be registered with it.
  always_comb begin
    busy_s  = (state_s != IDLE);
    done_s  = 1'b0;
    req_s   = 1'b0;
    we_s    = 1'b0;
    be_s    = 4'h0;
    addr_s  = 32'h0000_0000;
    wdata_s = 32'h0000_0000;
    case (state_s)
      RD_REQ: begin
        req_s  = 1'b1;
        addr_s = src_ptr_s;
      end
      WR_REQ: begin
        req_s   = 1'b1;
        we_s    = 1'b1;
        be_s    = BeFull;
        addr_s  = dst_ptr_s;
        wdata_s = data_s;
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      src_ptr_r   <= 32'h0000_0000;
      dst_ptr_r   <= 32'h0000_0000;
      remaining_r <= {LenW{1'b0}};
      mode_r      <= 1'b0;
      data_r      <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      src_ptr_r   <= src_ptr_s;
      dst_ptr_r   <= dst_ptr_s;
      remaining_r <= remaining_s;
      mode_r      <= mode_s;
      data_r      <= data_s;
    end
  end

  // Output registers; a request stays bit-for-bit stable while the state waits for gnt_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      be_r    <= 4'h0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else begin
      busy_r  <= busy_s;
      done_r  <= done_s;
      req_r   <= req_s;
      we_r    <= we_s;
      be_r    <= be_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign req_o   = req_r;
  assign we_o    = we_r;
  assign be_o    = be_r;
  assign addr_o  = addr_r;
  assign wdata_o = wdata_r;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: table of transfers against a small RAM model,
// plus hand sequences for reset mid-copy and the reset-state check.
module tb_mem_copy_dma;

  localparam int LenW = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            mode_i = 1'b0;
  logic [31:0]     src_i = 32'h0;
  logic [31:0]     dst_i = 32'h0;
  logic [LenW-1:0] len_i = '0;
  logic [31:0]     pattern_i = 32'h0;
  logic            busy_o, done_o, req_o, we_o, gnt_i;
  logic [3:0]      be_o;
  logic [31:0]     addr_o, wdata_o;
  logic            rvalid_i = 1'b0;
  logic [31:0]     rdata_i = 32'h0;

  mem_copy_dma #(.LenW(LenW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .src_i(src_i), .dst_i(dst_i), .len_i(len_i), .pattern_i(pattern_i),
    .busy_o(busy_o), .done_o(done_o), .req_o(req_o), .gnt_i(gnt_i),
    .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: 256 words, response one cycle after grant; optional 3-cycle grant stall.
  logic [31:0] mem [0:255];
  int          wait_cnt = 0;
  bit          stall_en = 1'b0;
  assign gnt_i = stall_en ? (wait_cnt == 3) : 1'b1;

  always @(posedge clk_i) begin
    rvalid_i <= req_o && gnt_i;
    if (req_o && gnt_i) begin
      wait_cnt <= 0;
      if (we_o) mem[addr_o[9:2]] = wdata_o;
      else rdata_i <= mem[addr_o[9:2]];
    end else if (req_o) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] addr_log [$];
  bit          prev_wait = 1'b0;
  logic [68:0] snap;

  // Bus-format and stall-hold checks on every request cycle.
  always @(negedge clk_i) begin
    if (req_o) begin
      n_cmp++;
      if (be_o !== (we_o ? 4'hF : 4'h0) || addr_o[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL req_fmt: we=%b be=%h addr=%h, required be=%h and aligned addr",
                 we_o, be_o, addr_o, (we_o ? 4'hF : 4'h0));
      end
      if (prev_wait) begin
        n_cmp++;
        if ({we_o, be_o, addr_o, wdata_o} !== snap) begin
          n_fail++;
          $display("FAIL stall_hold: got %h required %h", {we_o, be_o, addr_o, wdata_o}, snap);
        end
      end
    end else if (prev_wait) begin
      n_cmp++;
      n_fail++;
      $display("FAIL stall_hold: req_o got 0 required 1 before grant");
    end
    prev_wait = req_o && !gnt_i;
    snap = {we_o, be_o, addr_o, wdata_o};
    if (req_o && gnt_i) begin
      addr_log.push_back(addr_o);
      if (we_o) n_wr++;
      else n_rd++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          mode;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    logic [31:0] pat;
    bit          stall;
    int          extra_start;
    bit          start_at_done;
    int          exp_done;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  // Start one transfer and watch it; cycle k is the cycle after clock edge k-1, start at edge 0.
  task automatic run(input vec_t v, output int done_cyc, output int pulses, output int busy_cyc);
    done_cyc = 0;
    pulses   = 0;
    busy_cyc = 0;
    @(negedge clk_i);
    n_rd = 0;
    n_wr = 0;
    addr_log.delete();
    stall_en  = v.stall;
    mode_i    = v.mode;
    src_i     = v.src;
    dst_i     = v.dst;
    len_i     = LenW'(v.len);
    pattern_i = v.pat;
    start_i   = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_i);
      if (busy_o) busy_cyc++;
      if (done_o) begin
        pulses++;
        if (done_cyc == 0) done_cyc = k;
        if (v.start_at_done) begin
          start_i = 1'b1;
          mode_i  = 1'b1;
          len_i   = LenW'(5);
        end
      end
      if (k == v.extra_start) begin
        start_i   = 1'b1;
        mode_i    = 1'b1;
        len_i     = LenW'(5);
        pattern_i = 32'hBAD0_BAD0;
      end
      @(posedge clk_i);
      #1 start_i = 1'b0;
      if (done_cyc != 0 && k >= done_cyc + 3) break;
    end
    stall_en = 1'b0;
  endtask

  vec_t        vecs [7];
  logic [31:0] exp_data [0:15];
  logic [7:0]  idx;
  int          d_cyc, d_pulses, d_busy;

  initial begin
    for (int w = 0; w < 256; w++) mem[w] = 32'h5A00_0000 | 32'(w);
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[3] = 32'h4444_4444;

    //         mode  src           dst           len pat            stall xs xd done rd wr
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0100, 4, 32'h0,         1'b0, 0, 1'b0, 17, 4, 4};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0040, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0,  7, 0, 3};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h0000_0180, 2, 32'h0,         1'b1, 0, 1'b0, 21, 2, 2};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0110, 0, 32'h0,         1'b0, 0, 1'b0,  1, 0, 0};
    vecs[4] = '{1'b0, 32'h0000_01FE, 32'h0000_0302, 2, 32'h0,         1'b0, 0, 1'b0,  9, 2, 2};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_00C0, 2, 32'hCAFE_F00D, 1'b1, 0, 1'b0, 11, 0, 2};
    vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0200, 2, 32'h0,         1'b0, 3, 1'b1,  9, 2, 2};

    repeat (2) @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_req_we_be", {25'h0, req_o, we_o, be_o, 1'b0}, 32'h0);
    check("rst_addr", addr_o, 32'h0);
    check("rst_wdata", wdata_o, 32'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].len; j++) begin
        idx = vecs[i].src[9:2] + 8'(j);
        exp_data[j] = vecs[i].mode ? vecs[i].pat : mem[idx];
      end
      run(vecs[i], d_cyc, d_pulses, d_busy);
      check($sformatf("v%0d_done_cycle", i), 32'(d_cyc), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_done_pulses", i), 32'(d_pulses), 32'd1);
      check($sformatf("v%0d_busy_cycles", i), 32'(d_busy), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_reads", i), 32'(n_rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_writes", i), 32'(n_wr), 32'(vecs[i].exp_wr));
      for (int j = 0; j < vecs[i].len; j++) begin
        idx = vecs[i].dst[9:2] + 8'(j);
        check($sformatf("v%0d_data%0d", i, j), mem[idx], exp_data[j]);
      end
      if (i == 4) begin
        check("misaligned_first_rd", (addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF, 32'h0000_01FC);
        check("misaligned_first_wr", (addr_log.size() > 1) ? addr_log[1] : 32'hFFFF_FFFF, 32'h0000_0300);
        check("misaligned_next_rd", (addr_log.size() > 2) ? addr_log[2] : 32'hFFFF_FFFF, 32'h0000_0200);
      end
    end

    // Reset in RD_WAIT; the in-flight read response lands after reset is released.
    @(negedge clk_i);
    mode_i  = 1'b0;
    src_i   = 32'h0000_0000;
    dst_i   = 32'h0000_0380;
    len_i   = LenW'(4);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_rd_req", {31'h0, req_o}, 32'h1);
    @(negedge clk_i);
    check("rstmid_in_rd_wait", {30'h0, busy_o, req_o}, 32'h2);
    rst_ni = 1'b0;
    #1;
    check("rstmid_flags", {28'h0, busy_o, done_o, req_o, we_o}, 32'h0);
    check("rstmid_be", 32'(be_o), 32'h0);
    check("rstmid_addr", addr_o, 32'h0);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("rstmid_stays_idle", {28'h0, busy_o, done_o, req_o, we_o}, 32'h0);
    check("rstmid_no_write", mem[8'hE0], 32'h5A00_00E0);

    begin
      vec_t after;
      after = '{1'b1, 32'h0, 32'h0000_0384, 1, 32'h1234_5678, 1'b0, 0, 1'b0, 3, 0, 1};
      run(after, d_cyc, d_pulses, d_busy);
      check("after_rst_done_cycle", 32'(d_cyc), 32'd3);
      check("after_rst_pulses", 32'(d_pulses), 32'd1);
      check("after_rst_writes", 32'(n_wr), 32'd1);
      check("after_rst_data", mem[8'hE1], 32'h1234_5678);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
